// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Instruction-memory fetch channel between the PC sequencer and the memory.
//   imemReq   : fetch request, held until accepted (sequencer -> memory)
//   imemAddr  : fetch address (sequencer -> memory)
//   imemReady : memory accepts the request this cycle (memory -> sequencer)
//   imemValid : instruction data valid this cycle (memory -> sequencer)
//   imemData  : fetched instruction word (memory -> sequencer)
// ---------------------------------------------------------------------------
interface pc_sequencer_if;
  localparam int unsigned XLEN = 32;

  logic            imemReq;
  logic [XLEN-1:0] imemAddr;
  logic            imemReady;
  logic            imemValid;
  logic [XLEN-1:0] imemData;

  // Sequencer side
  modport master (
    output imemReq,
    output imemAddr,
    input  imemReady,
    input  imemValid,
    input  imemData
  );

  // Memory side
  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemReady,
    output imemValid,
    output imemData
  );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter of the single-issue core: fetches each instruction,
// hands it to the decoder/datapath, then picks the next PC from the decoder
// flags and the branch-compare result. Halts on ecall or misaligned target.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   imem         : fetch channel (pc_sequencer_if.master)
//   inCode       : latched instruction word for decoder/datapath
//   instrValid   : one-cycle pulse when inCode is updated
//   branch/jump/ecall, jumpAddr : decoder flags and PC-relative offset
//   branchTaken  : datapath compare result, used only with execDone
//   execDone     : datapath finished the current instruction
//   resume       : restart fetch from HALT
//   pc, halted, fault : current PC, halt status, misaligned-target halt
// All outputs are registered.
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_sequencer_if.master        imem,
  output logic [31:0]           inCode,
  output logic                  instrValid,
  input  logic                  branch,
  input  logic                  jump,
  input  logic                  ecall,
  input  logic [31:0]           jumpAddr,
  input  logic                  branchTaken,
  input  logic                  execDone,
  input  logic                  resume,
  output logic [31:0]           pc,
  output logic                  halted,
  output logic                  fault
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned INSTR_SZ = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_imem_req;
  logic [XLEN-1:0] r_in_code;
  logic            r_instr_valid;
  logic            r_halted;
  logic            r_fault;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_imem_req_nxt;
  logic [XLEN-1:0] w_in_code_nxt;
  logic            w_instr_valid_nxt;
  logic            w_halted_nxt;
  logic            w_fault_nxt;

  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_rel_pc;
  logic            w_take;
  logic [XLEN-1:0] w_target;

  // Candidate next-PC values; additions wrap modulo 2^32 by width.
  assign w_seq_pc = r_pc + XLEN'(INSTR_SZ);
  assign w_rel_pc = r_pc + jumpAddr;
  assign w_take   = jump | (branch & branchTaken);
  assign w_target = w_take ? w_rel_pc : w_seq_pc;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_in_code     <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_imem_req    <= w_imem_req_nxt;
      r_in_code     <= w_in_code_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_halted      <= w_halted_nxt;
      r_fault       <= w_fault_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_in_code_nxt     = r_in_code;
    w_instr_valid_nxt = 1'b0;
    w_fault_nxt       = r_fault;

    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // Any imemValid seen here is a stale response and is dropped.
        if (imem.imemReady) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imemValid) begin
          w_in_code_nxt     = imem.imemData;
          w_instr_valid_nxt = 1'b1;
          w_state_nxt       = S_EXEC;
        end
      end
      S_EXEC: begin
        if (execDone) begin
          if (ecall) begin
            w_pc_nxt    = w_seq_pc;
            w_fault_nxt = 1'b0;
            w_state_nxt = S_HALT;
          end else if (w_target[1:0] != 2'b00) begin
            // Misaligned target: keep the offending instruction's PC.
            w_fault_nxt = 1'b1;
            w_state_nxt = S_HALT;
          end else begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (resume) begin
          w_fault_nxt = 1'b0;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Request and halt flags track the state being entered so they are
    // registered in lockstep with it.
    w_imem_req_nxt = (w_state_nxt == S_FETCH);
    w_halted_nxt   = (w_state_nxt == S_HALT);
  end

  assign imem.imemReq  = r_imem_req;
  assign imem.imemAddr = r_pc;
  assign inCode        = r_in_code;
  assign instrValid    = r_instr_valid;
  assign pc            = r_pc;
  assign halted        = r_halted;
  assign fault         = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed plus randomized bench for pc_sequencer. A transaction-level model
// (expected PC, halt and fault) is advanced once per instruction from the
// next-PC rules; every observed output is compared against it.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] inCode;
  logic        instrValid;
  logic        branch;
  logic        jump;
  logic        ecall;
  logic [31:0] jumpAddr;
  logic        branchTaken;
  logic        execDone;
  logic        resume;
  logic [31:0] pc;
  logic        halted;
  logic        fault;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .inCode      (inCode),
    .instrValid  (instrValid),
    .branch      (branch),
    .jump        (jump),
    .ecall       (ecall),
    .jumpAddr    (jumpAddr),
    .branchTaken (branchTaken),
    .execDone    (execDone),
    .resume      (resume),
    .pc          (pc),
    .halted      (halted),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass;
  int          n_total;
  logic [31:0] exp_pc;
  logic        exp_halt;
  logic        exp_fault;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one instruction from FETCH through the execDone decision and
  // advance the reference model.
  task automatic run_instr(input int rw, input int vw, input int ew, input bit rsm_in_exec,
                           input logic [31:0] data, input logic br, input logic jp,
                           input logic ec, input logic bt, input logic [31:0] off);
    logic [31:0] tgt;
    chk("fetch_req", 32'(bus.imemReq), 32'd1);
    chk("fetch_addr", bus.imemAddr, exp_pc);
    chk("fetch_pc", pc, exp_pc);
    for (int i = 0; i < rw; i++) begin
      bus.imemReady = 1'b0;
      bus.imemValid = 1'($urandom_range(0, 1));
      bus.imemData  = $urandom;
      execDone      = 1'($urandom_range(0, 1));
      resume        = 1'($urandom_range(0, 1));
      tick();
      chk("stall_req", 32'(bus.imemReq), 32'd1);
      chk("stall_addr", bus.imemAddr, exp_pc);
    end
    // Accept; a simultaneous imemValid must be ignored.
    bus.imemReady = 1'b1;
    bus.imemValid = 1'($urandom_range(0, 1));
    bus.imemData  = 32'hDEAD_BEEF;
    execDone      = 1'b0;
    resume        = 1'b0;
    tick();
    bus.imemReady = 1'b0;
    bus.imemValid = 1'b0;
    chk("wait_req", 32'(bus.imemReq), 32'd0);
    chk("wait_iv", 32'(instrValid), 32'd0);
    for (int i = 0; i < vw; i++) begin
      execDone = 1'($urandom_range(0, 1));
      tick();
      chk("wait_iv_low", 32'(instrValid), 32'd0);
      chk("wait_req_low", 32'(bus.imemReq), 32'd0);
    end
    execDone      = 1'b0;
    bus.imemValid = 1'b1;
    bus.imemData  = data;
    tick();
    bus.imemValid = 1'b0;
    bus.imemData  = $urandom;
    chk("iv_pulse", 32'(instrValid), 32'd1);
    chk("incode", inCode, data);
    branch      = br;
    jump        = jp;
    ecall       = ec;
    jumpAddr    = off;
    branchTaken = 1'($urandom_range(0, 1));
    for (int i = 0; i < ew; i++) begin
      resume        = rsm_in_exec ? 1'b1 : 1'($urandom_range(0, 1));
      bus.imemValid = 1'($urandom_range(0, 1));
      tick();
      chk("exec_iv_low", 32'(instrValid), 32'd0);
      chk("exec_incode_hold", inCode, data);
      chk("exec_pc_hold", pc, exp_pc);
    end
    resume        = 1'b0;
    bus.imemValid = 1'b0;
    branchTaken   = bt;
    execDone      = 1'b1;
    tick();
    execDone = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    ecall    = 1'b0;
    // Reference next-PC rules
    if (ec) begin
      exp_pc    = exp_pc + 32'd4;
      exp_halt  = 1'b1;
      exp_fault = 1'b0;
    end else begin
      tgt = (jp || (br && bt)) ? exp_pc + off : exp_pc + 32'd4;
      if (tgt % 4 != 0) begin
        exp_halt  = 1'b1;
        exp_fault = 1'b1;
      end else begin
        exp_pc = tgt;
      end
    end
    chk("post_pc", pc, exp_pc);
    chk("post_halted", 32'(halted), 32'(exp_halt));
    chk("post_fault", 32'(fault), 32'(exp_fault));
    chk("post_req", 32'(bus.imemReq), 32'(!exp_halt));
    chk("post_iv", 32'(instrValid), 32'd0);
    chk("post_incode", inCode, data);
  endtask

  // Sit in HALT for hw cycles, then resume.
  task automatic resume_halt(input int hw);
    for (int i = 0; i < hw; i++) begin
      resume        = 1'b0;
      bus.imemValid = 1'($urandom_range(0, 1));
      execDone      = 1'($urandom_range(0, 1));
      tick();
      chk("halt_hold", 32'(halted), 32'd1);
      chk("halt_req", 32'(bus.imemReq), 32'd0);
      chk("halt_pc", pc, exp_pc);
      chk("halt_fault", 32'(fault), 32'(exp_fault));
    end
    bus.imemValid = 1'b0;
    execDone      = 1'b0;
    resume        = 1'b1;
    tick();
    resume    = 1'b0;
    exp_halt  = 1'b0;
    exp_fault = 1'b0;
    chk("resume_req", 32'(bus.imemReq), 32'd1);
    chk("resume_addr", bus.imemAddr, exp_pc);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_fault", 32'(fault), 32'd0);
  endtask

  initial begin
    logic [31:0] off;
    logic        ec;
    n_pass        = 0;
    n_total       = 0;
    exp_pc        = 32'h0;
    exp_halt      = 1'b0;
    exp_fault     = 1'b0;
    rst           = 1'b1;
    branch        = 1'b0;
    jump          = 1'b0;
    ecall         = 1'b0;
    jumpAddr      = 32'h0;
    branchTaken   = 1'b0;
    execDone      = 1'b0;
    resume        = 1'b0;
    bus.imemReady = 1'b0;
    bus.imemValid = 1'b1;
    bus.imemData  = 32'hBAD0_BAD0;

    // Reset with a stale response on the bus
    for (int i = 0; i < 3; i++) tick();
    chk("rst_req", 32'(bus.imemReq), 32'd0);
    chk("rst_addr", bus.imemAddr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_incode", inCode, 32'h0);
    chk("rst_iv", 32'(instrValid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    rst = 1'b0;
    chk("idle_req", 32'(bus.imemReq), 32'd0);
    tick();
    bus.imemValid = 1'b0;
    chk("first_req", 32'(bus.imemReq), 32'd1);
    chk("first_iv", 32'(instrValid), 32'd0);

    // Sequential zero-wait run: 0x0, 0x4, 0x8
    run_instr(0, 0, 0, 0, 32'h0000_0013, 0, 0, 0, 0, 32'h0);
    run_instr(0, 0, 0, 0, 32'h0010_0093, 0, 0, 0, 0, 32'h0);
    run_instr(0, 0, 0, 0, 32'h0020_0113, 0, 0, 0, 0, 32'h0);
    // Memory stalls at 0xC, jump to 0x100
    run_instr(4, 3, 0, 0, 32'h0F40_006F, 0, 1, 0, 0, 32'h0000_00F4);
    // Branch resolution at 0x100
    run_instr(0, 0, 1, 0, 32'hFE00_08E3, 1, 0, 0, 1, 32'hFFFF_FFF0);
    run_instr(0, 0, 0, 0, 32'h0100_006F, 0, 1, 0, 0, 32'h0000_0010);
    run_instr(0, 0, 2, 0, 32'hFE00_08E3, 1, 0, 0, 0, 32'hFFFF_FFF0);
    run_instr(0, 0, 0, 0, 32'hFFDF_F06F, 0, 1, 0, 0, 32'hFFFF_FFFC);
    run_instr(1, 1, 1, 0, 32'h0000_086F, 0, 1, 0, 0, 32'h0000_0800);
    // Wrap: reach 0xFFFF_FFFC, then sequential to 0x0
    run_instr(0, 0, 0, 0, 32'h0000_006F, 0, 1, 0, 0, 32'hFFFF_F6FC);
    run_instr(0, 0, 0, 0, 32'h0000_0013, 0, 0, 0, 0, 32'h0);
    // Ecall (with jump) at 0x20, resume held in EXEC
    run_instr(0, 0, 0, 0, 32'h0200_006F, 0, 1, 0, 0, 32'h0000_0020);
    run_instr(0, 0, 2, 1, 32'h0000_0073, 0, 1, 1, 0, 32'h0000_0040);
    resume_halt(3);
    // Misaligned jump target at 0x24
    run_instr(0, 0, 0, 0, 32'h0060_006F, 0, 1, 0, 0, 32'h0000_0006);
    resume_halt(2);
    // branch and jump together: jump wins regardless of branchTaken
    run_instr(0, 0, 0, 0, 32'h0100_006F, 1, 1, 0, 0, 32'h0000_0010);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) off = $urandom;
      else off = ($urandom & 32'h0000_03FC) | ($urandom_range(0, 1) != 0 ? 32'hFFFF_FC00 : 32'h0);
      ec = ($urandom_range(0, 7) == 0);
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0,
                $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ec,
                1'($urandom_range(0, 1)), off);
      if (exp_halt) resume_halt(int'($urandom_range(0, 2)));
    end

    // Reset while in WAIT; late response must be dropped
    bus.imemReady = 1'b1;
    tick();
    bus.imemReady = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_req", 32'(bus.imemReq), 32'd0);
    chk("mid_rst_iv", 32'(instrValid), 32'd0);
    chk("mid_rst_incode", inCode, 32'h0);
    rst           = 1'b0;
    bus.imemValid = 1'b1;
    bus.imemData  = 32'h1234_5678;
    tick();
    chk("mid_late_iv", 32'(instrValid), 32'd0);
    chk("mid_refetch_req", 32'(bus.imemReq), 32'd1);
    chk("mid_refetch_addr", bus.imemAddr, 32'h0);
    tick();
    bus.imemValid = 1'b0;
    chk("mid_late_iv2", 32'(instrValid), 32'd0);
    chk("mid_incode_kept", inCode, 32'h0);
    exp_pc    = 32'h0;
    exp_halt  = 1'b0;
    exp_fault = 1'b0;
    run_instr(0, 0, 0, 0, 32'hCAFE_0013, 0, 0, 0, 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
